// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 crypto subsystem DMA master.
package sm3_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_FEED,
        ST_WAIT_DIG,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_DONE,
        ST_ERR
    } dma_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam int DIGEST_WORDS_DEF = 8;

    // Word pointer to bus byte address; pointers are 13-bit so they wrap on their own.
    function automatic logic [31:0] word_to_byte(input logic [31:0] base, input logic [12:0] waddr);
        return base + {17'd0, waddr, 2'b00};
    endfunction

endpackage

// File: rtl/ahb_single_xfer.sv
// Single, non-pipelined AHB-Lite transfer engine: one NONSEQ address cycle
// (while req is high) followed by a data phase that lasts until HREADY.
module ahb_single_xfer
    import sm3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    logic        dphase_q;
    logic [31:0] wdata_q;

    // Address phase is driven only while req is high; the bus is IDLE otherwise.
    assign haddr  = req ? addr : 32'd0;
    assign htrans = req ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite = req & write;
    assign hsize  = HSIZE_WORD;
    assign hwdata = wdata_q;
    assign rdata  = hrdata;

    // An error response ends the data phase regardless of HREADY.
    assign done = dphase_q & hready & ~hresp;
    assign err  = dphase_q & hresp;

    // Track the data phase and hold the write word stable across wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dphase_q <= 1'b0;
            wdata_q  <= 32'd0;
        end else begin
            if (req) begin
                dphase_q <= 1'b1;
            end else if (hready || hresp) begin
                dphase_q <= 1'b0;
            end
            if (req && write) begin
                wdata_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/ahb_dma_master.sv
// AHB-Lite DMA master: streams a message from memory into the SM3 core and
// writes the resulting digest back, then pulses SET_STR.
module ahb_dma_master
    import sm3_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          DIGEST_WORDS = DIGEST_WORDS_DEF
) (
    input  logic        AHB_HCLK,
    input  logic        AHB_HRESETN,
    input  logic        ENABLE,
    input  logic [1:0]  CMDR,
    input  logic [12:0] SAR_ADDR,
    input  logic [12:0] DAR_ADDR,
    input  logic [12:0] BSR,
    output logic        SET_STR,
    output logic        DMA_ERR,
    output logic        BUSY,
    output logic [31:0] AHB_M_HADDR,
    output logic [1:0]  AHB_M_HTRANS,
    output logic        AHB_M_HWRITE,
    output logic [2:0]  AHB_M_HSIZE,
    output logic [31:0] AHB_M_HWDATA,
    input  logic [31:0] AHB_M_HRDATA,
    input  logic        AHB_M_HREADY,
    input  logic        AHB_M_HRESP,
    output logic [1:0]  CORE_CMD,
    output logic [31:0] CORE_DIN,
    output logic        CORE_DIN_VALID,
    output logic        CORE_DIN_LAST,
    input  logic        CORE_DIN_READY,
    input  logic [31:0] CORE_DOUT,
    input  logic        CORE_DOUT_VALID,
    output logic        CORE_DOUT_READY
);

    localparam int DCW = $clog2(DIGEST_WORDS + 1);

    dma_state_t     state_q, state_d;
    logic           en_q;
    logic [12:0]    src_ptr, dst_ptr, remaining;
    logic [DCW-1:0] dig_cnt;
    logic [31:0]    buf_q, dig_q;
    logic [1:0]     cmd_q;
    logic           dma_err_q;

    logic           x_req, x_write, x_done, x_err;
    logic [31:0]    x_addr, x_rdata;
    logic           start, feed_hs, dig_hs, wr_ok, go_err, rd_ok;
    logic           set_str, busy, din_valid, din_last, dout_ready;

    ahb_single_xfer u_xfer (
        .clk    (AHB_HCLK),
        .rst_n  (AHB_HRESETN),
        .req    (x_req),
        .addr   (x_addr),
        .write  (x_write),
        .wdata  (dig_q),
        .rdata  (x_rdata),
        .done   (x_done),
        .err    (x_err),
        .haddr  (AHB_M_HADDR),
        .htrans (AHB_M_HTRANS),
        .hwrite (AHB_M_HWRITE),
        .hsize  (AHB_M_HSIZE),
        .hwdata (AHB_M_HWDATA),
        .hrdata (AHB_M_HRDATA),
        .hready (AHB_M_HREADY),
        .hresp  (AHB_M_HRESP)
    );

    // State register.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Job sequencing: next state, bus requests, core handshakes and datapath strobes.
    always_comb begin
        state_d    = state_q;
        x_req      = 1'b0;
        x_write    = 1'b0;
        x_addr     = word_to_byte(BASE_ADDR, src_ptr);
        start      = 1'b0;
        feed_hs    = 1'b0;
        dig_hs     = 1'b0;
        wr_ok      = 1'b0;
        rd_ok      = 1'b0;
        go_err     = 1'b0;
        set_str    = 1'b0;
        busy       = 1'b1;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (ENABLE && !en_q) begin
                    start   = 1'b1;
                    state_d = (BSR == 13'd0) ? ST_DONE : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                // No address is issued on an abort so the bus never sees an orphan transfer.
                x_req   = ENABLE;
                state_d = ENABLE ? ST_RD_DATA : ST_IDLE;
            end
            ST_RD_DATA: begin
                if (x_err) begin
                    go_err  = 1'b1;
                    state_d = ST_ERR;
                end else if (x_done) begin
                    rd_ok   = 1'b1;
                    state_d = ENABLE ? ST_FEED : ST_IDLE;
                end
            end
            ST_FEED: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                end else begin
                    din_valid = 1'b1;
                    din_last  = (remaining == 13'd1);
                    if (CORE_DIN_READY) begin
                        feed_hs = 1'b1;
                        state_d = (remaining == 13'd1) ? ST_WAIT_DIG : ST_RD_ADDR;
                    end
                end
            end
            ST_WAIT_DIG: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                end else begin
                    dout_ready = 1'b1;
                    if (CORE_DOUT_VALID) begin
                        dig_hs  = 1'b1;
                        state_d = ST_WR_ADDR;
                    end
                end
            end
            ST_WR_ADDR: begin
                x_req   = 1'b1;
                x_write = 1'b1;
                x_addr  = word_to_byte(BASE_ADDR, dst_ptr);
                state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (x_err) begin
                    go_err  = 1'b1;
                    state_d = ST_ERR;
                end else if (x_done) begin
                    wr_ok = 1'b1;
                    if (!ENABLE)                                   state_d = ST_IDLE;
                    else if (dig_cnt == DCW'(DIGEST_WORDS - 1))    state_d = ST_DONE;
                    else                                           state_d = ST_WAIT_DIG;
                end
            end
            ST_DONE: begin
                set_str = ENABLE;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                busy = 1'b0;
                if (!ENABLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Job parameters latched at start, pointers/counters and data holding registers.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETN) begin
        if (!AHB_HRESETN) begin
            en_q      <= 1'b0;
            src_ptr   <= 13'd0;
            dst_ptr   <= 13'd0;
            remaining <= 13'd0;
            dig_cnt   <= '0;
            buf_q     <= 32'd0;
            dig_q     <= 32'd0;
            cmd_q     <= 2'd0;
            dma_err_q <= 1'b0;
        end else begin
            en_q <= ENABLE;
            if (start) begin
                src_ptr   <= SAR_ADDR;
                dst_ptr   <= DAR_ADDR;
                remaining <= BSR;
                cmd_q     <= CMDR;
                dig_cnt   <= '0;
                dma_err_q <= 1'b0;
            end
            if (rd_ok) buf_q <= x_rdata;
            if (feed_hs) begin
                src_ptr   <= src_ptr + 13'd1;
                remaining <= remaining - 13'd1;
            end
            if (dig_hs) dig_q <= CORE_DOUT;
            if (wr_ok) begin
                dst_ptr <= dst_ptr + 13'd1;
                dig_cnt <= dig_cnt + DCW'(1);
            end
            if (go_err) dma_err_q <= 1'b1;
        end
    end

    assign SET_STR         = set_str;
    assign DMA_ERR         = dma_err_q;
    assign BUSY            = busy;
    assign CORE_CMD        = cmd_q;
    assign CORE_DIN        = buf_q;
    assign CORE_DIN_VALID  = din_valid;
    assign CORE_DIN_LAST   = din_last;
    assign CORE_DOUT_READY = dout_ready;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Randomized bench for ahb_dma_master: an AHB memory/core model records every
// transfer and handshake, and each job is compared against expectations
// computed directly from the job parameters.
module tb_ahb_dma_master;
    import sm3_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NDIG = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  cmdr = 2'd0;
    logic [12:0] sar = 13'd0, dar = 13'd0, bsr = 13'd0;
    logic [31:0] hrdata = 32'd0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic        din_ready = 1'b0;
    logic [31:0] dout = 32'd0;
    logic        dout_valid = 1'b0;

    logic        set_str, dma_err, busy, hwrite, din_valid, din_last, dout_ready;
    logic [31:0] haddr, hwdata, core_din;
    logic [1:0]  htrans, core_cmd;
    logic [2:0]  hsize;

    always #5 clk = ~clk;

    ahb_dma_master #(.BASE_ADDR(BASE), .DIGEST_WORDS(NDIG)) dut (
        .AHB_HCLK(clk), .AHB_HRESETN(rst_n), .ENABLE(enable), .CMDR(cmdr),
        .SAR_ADDR(sar), .DAR_ADDR(dar), .BSR(bsr), .SET_STR(set_str),
        .DMA_ERR(dma_err), .BUSY(busy), .AHB_M_HADDR(haddr), .AHB_M_HTRANS(htrans),
        .AHB_M_HWRITE(hwrite), .AHB_M_HSIZE(hsize), .AHB_M_HWDATA(hwdata),
        .AHB_M_HRDATA(hrdata), .AHB_M_HREADY(hready), .AHB_M_HRESP(hresp),
        .CORE_CMD(core_cmd), .CORE_DIN(core_din), .CORE_DIN_VALID(din_valid),
        .CORE_DIN_LAST(din_last), .CORE_DIN_READY(din_ready), .CORE_DOUT(dout),
        .CORE_DOUT_VALID(dout_valid), .CORE_DOUT_READY(dout_ready)
    );

    // Reference memory, digest source and observation records.
    logic [31:0] mem [8192];
    logic [31:0] digest [NDIG];
    logic [31:0] rd_addr[$], wr_addr[$], wr_data[$], din_q[$];
    logic        last_q[$];
    int          nonseq_cnt, set_cnt, stab_err;
    bit          wr_stall_seen;
    int          hwait = 0, dstall = 0, err_rd_idx = -1, dig_avail = NDIG;
    int          clr_gen = 0, seen_gen = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory slave and SM3 core stand-in, reacting on the falling edge.
    initial begin : bus_core_model
        bit          dph, dph_wr, dph_err, dfirst, din_stall, armed, dhs_pend;
        logic [31:0] dph_addr, hold, din_hold;
        int          wcnt, dcnt, didx;
        dph = 0; dph_wr = 0; dph_err = 0; dfirst = 0; din_stall = 0; armed = 0; dhs_pend = 0;
        dph_addr = 0; hold = 0; din_hold = 0; wcnt = 0; dcnt = 0; didx = 0;
        nonseq_cnt = 0; set_cnt = 0; stab_err = 0; wr_stall_seen = 0;
        forever begin
            @(negedge clk);
            hresp = 1'b0;
            if (clr_gen != seen_gen) begin
                rd_addr.delete(); wr_addr.delete(); wr_data.delete();
                din_q.delete(); last_q.delete();
                nonseq_cnt = 0; set_cnt = 0; stab_err = 0; wr_stall_seen = 0;
            end
            if (!rst_n || clr_gen != seen_gen) begin
                seen_gen = clr_gen;
                dph = 0; hready = 1'b1; din_ready = 1'b0; dout_valid = 1'b0; dout = 32'd0;
                armed = 0; didx = 0; dhs_pend = 0; din_stall = 0;
            end else begin
                if (dph) begin
                    if (dfirst) begin hold = hwdata; dfirst = 0; end
                    else if (dph_wr && hwdata !== hold) stab_err++;
                    if (wcnt > 0) begin
                        hready = 1'b0;
                        wcnt--;
                        if (dph_wr) wr_stall_seen = 1'b1;
                    end else begin
                        hready = 1'b1;
                        dph = 0;
                        if (dph_wr) begin
                            wr_addr.push_back(dph_addr);
                            wr_data.push_back(hwdata);
                        end else begin
                            hrdata = mem[13'((dph_addr - BASE) >> 2)];
                            hresp  = dph_err;
                        end
                    end
                end
                if (htrans == HTRANS_NONSEQ) begin
                    nonseq_cnt++;
                    dph = 1; dph_addr = haddr; dph_wr = hwrite; dph_err = 0; dfirst = 1; wcnt = hwait;
                    if (!hwrite) begin
                        dph_err = (rd_addr.size() == err_rd_idx);
                        rd_addr.push_back(haddr);
                    end
                end
                if (din_valid) begin
                    if (!din_stall) begin din_hold = core_din; din_stall = 1; dcnt = dstall; end
                    else if (core_din !== din_hold) stab_err++;
                    if (dcnt > 0) begin
                        din_ready = 1'b0;
                        dcnt--;
                    end else begin
                        din_ready = 1'b1;
                        din_q.push_back(core_din);
                        last_q.push_back(din_last);
                        din_stall = 0;
                        if (din_last) armed = 1;
                    end
                end else begin
                    din_ready = 1'b0;
                end
                if (dhs_pend) begin didx++; dhs_pend = 0; end
                dout_valid = armed && didx < dig_avail && didx < NDIG;
                dout = dout_valid ? digest[didx] : 32'd0;
                if (dout_valid && dout_ready) dhs_pend = 1;
            end
            if (set_str) set_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr_models();
        clr_gen++;
        tick(1);
    endtask

    // Run one complete job and compare everything observed with the expected transaction list.
    task automatic run_job(input string tag, input int s, input int d, input int b,
                           input logic [1:0] c, input int hw, input int ds);
        int t, nwr;
        clr_models();
        hwait = hw; dstall = ds; err_rd_idx = -1; dig_avail = NDIG;
        foreach (digest[i]) digest[i] = $urandom;
        sar = 13'(s); dar = 13'(d); bsr = 13'(b); cmdr = c; enable = 1'b1;
        tick(2);
        // Register block changes mid-job must be ignored.
        sar = 13'($urandom); dar = 13'($urandom); bsr = 13'($urandom); cmdr = 2'($urandom);
        t = 0;
        while (set_cnt == 0 && !dma_err && t < 5000) begin tick(1); t++; end
        tick(6);
        nwr = (b == 0) ? 0 : NDIG;
        chk({tag, ".set_str"}, 32'(set_cnt), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".dma_err"}, 32'(dma_err), 32'd0);
        chk({tag, ".cmd"}, 32'(core_cmd), 32'(c));
        chk({tag, ".stable"}, 32'(stab_err), 32'd0);
        chk({tag, ".nonseq"}, 32'(nonseq_cnt), 32'(b + nwr));
        chk({tag, ".nrd"}, 32'(rd_addr.size()), 32'(b));
        chk({tag, ".ndin"}, 32'(din_q.size()), 32'(b));
        for (int i = 0; i < b && i < rd_addr.size() && i < din_q.size(); i++) begin
            int w = (s + i) % 8192;
            chk({tag, ".rd_addr"}, rd_addr[i], BASE + 32'(w * 4));
            chk({tag, ".din"}, din_q[i], mem[w]);
            chk({tag, ".last"}, 32'(last_q[i]), 32'(i == b - 1));
        end
        chk({tag, ".nwr"}, 32'(wr_addr.size()), 32'(nwr));
        for (int i = 0; i < nwr && i < wr_addr.size(); i++) begin
            int w = (d + i) % 8192;
            chk({tag, ".wr_addr"}, wr_addr[i], BASE + 32'(w * 4));
            chk({tag, ".wr_data"}, wr_data[i], digest[i]);
        end
        enable = 1'b0;
        tick(2);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int t;
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        #1 rst_n = 1'b0;
        #11;
        chk("rst.htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst.hsize", 32'(hsize), 32'(3'b010));
        chk("rst.haddr", haddr, 32'd0);
        chk("rst.hwdata", hwdata, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.set_str", 32'(set_str), 32'd0);
        chk("rst.dma_err", 32'(dma_err), 32'd0);
        chk("rst.din_valid", 32'(din_valid), 32'd0);
        chk("rst.dout_ready", 32'(dout_ready), 32'd0);
        chk("rst.core_din", core_din, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(2);

        // Directed job: three words at 0x010, digest to 0x100.
        mem[16] = 32'hA; mem[17] = 32'hB; mem[18] = 32'hC;
        run_job("tp1", 'h10, 'h100, 3, 2'b01, 0, 0);
        if (rd_addr.size() == 3 && wr_addr.size() == NDIG) begin
            chk("tp1.rd0", rd_addr[0], 32'h40);
            chk("tp1.rd2", rd_addr[2], 32'h48);
            chk("tp1.din2", din_q[2], 32'hC);
            chk("tp1.wr0", wr_addr[0], 32'h400);
            chk("tp1.wr7", wr_addr[7], 32'h41C);
        end

        run_job("stall", 'h10, 'h100, 3, 2'b10, 3, 2);

        run_job("wrap", 'h1FFF, 'h1FFE, 2, 2'b11, 1, 1);
        if (rd_addr.size() == 2) begin
            chk("wrap.rd0", rd_addr[0], 32'h7FFC);
            chk("wrap.rd1", rd_addr[1], 32'h0);
        end

        run_job("bsr0", 'h30, 'h300, 0, 2'b01, 0, 0);

        // Bus error on the second read.
        clr_models();
        hwait = 1; dstall = 0; err_rd_idx = 1; dig_avail = NDIG;
        sar = 13'h20; dar = 13'h200; bsr = 13'd4; cmdr = 2'd0; enable = 1'b1;
        t = 0;
        while (!dma_err && t < 500) begin tick(1); t++; end
        chk("err.dma_err", 32'(dma_err), 32'd1);
        tick(5);
        chk("err.busy", 32'(busy), 32'd0);
        chk("err.set_str", 32'(set_cnt), 32'd0);
        chk("err.nrd", 32'(rd_addr.size()), 32'd2);
        chk("err.nonseq", 32'(nonseq_cnt), 32'd2);
        chk("err.ndin", 32'(din_q.size()), 32'd1);
        enable = 1'b0;
        tick(2);
        chk("err.sticky", 32'(dma_err), 32'd1);
        err_rd_idx = -1;
        run_job("post_err", 'h21, 'h210, 2, 2'b00, 0, 0);

        // Abort while waiting for the fourth digest word.
        clr_models();
        hwait = 1; dstall = 0; err_rd_idx = -1; dig_avail = 3;
        foreach (digest[i]) digest[i] = $urandom;
        sar = 13'h40; dar = 13'h400; bsr = 13'd2; enable = 1'b1;
        t = 0;
        while (!(wr_addr.size() == 3 && dout_ready) && t < 1000) begin tick(1); t++; end
        chk("abort.reached", 32'(wr_addr.size()), 32'd3);
        enable = 1'b0;
        tick(2);
        chk("abort.busy", 32'(busy), 32'd0);
        tick(6);
        chk("abort.nwr", 32'(wr_addr.size()), 32'd3);
        chk("abort.set_str", 32'(set_cnt), 32'd0);
        chk("abort.nonseq", 32'(nonseq_cnt), 32'd5);
        dig_avail = NDIG;

        // Asynchronous reset in the middle of a stalled write data phase.
        clr_models();
        hwait = 3; dstall = 0; err_rd_idx = -1; dig_avail = NDIG;
        foreach (digest[i]) digest[i] = $urandom;
        sar = 13'h50; dar = 13'h500; bsr = 13'd1; enable = 1'b1;
        t = 0;
        while (!wr_stall_seen && t < 1000) begin tick(1); t++; end
        chk("rst_mid.reached", 32'(wr_stall_seen), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.htrans", 32'(htrans), 32'(HTRANS_IDLE));
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.hwdata", hwdata, 32'd0);
        chk("rst_mid.dout_ready", 32'(dout_ready), 32'd0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("rst_mid.idle", 32'(busy), 32'd0);
        chk("rst_mid.nwr", 32'(wr_addr.size()), 32'd0);
        run_job("post_rst", 'h60, 'h600, 2, 2'b10, 1, 0);

        for (int k = 0; k < 6; k++) begin
            run_job("rand", int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
                    int'($urandom_range(1, 12)), 2'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
